// File: rtl/decode_stage.sv
// Decode stage of the 5-stage RV32I pipeline: register file, immediate
// generation, control decode and the ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            flush_e,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [2:0]      Funct3E,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            ALUSrcE,
  output logic            ALUSrcAE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            JalrE,
  output logic            IllegalE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_IMM   = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_BR    = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND  = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL  = 4'd6, ALU_SRA = 4'd7,
    ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10
  } alu_e;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            alu_src_a;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
    logic [1:0]      result_src;
    alu_e            alu_ctl;
  } idex_t;

  // The NOP encoding needs no special case: it decodes naturally as addi x0,x0,0.
  logic unused_nop;
  assign unused_nop = ^NOP_INSTR;

  logic [XLEN-1:0] rf_q [1:31];
  logic [XLEN-1:0] rd1, rd2;
  idex_t           ex_d, ex_q;

  // ALU operation from funct3; alt selects SUB/SRA where applicable.
  function automatic alu_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign Rs1D = instrD[19:15];
  assign Rs2D = instrD[24:20];

  // Register file write port; x0 is not stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf_q[RdW] <= ResultW;
    end
  end

  // Combinational reads with write-through of the current writeback.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (Rs1D != 5'd0) rd1 = (RegWriteW && RdW == Rs1D) ? ResultW : rf_q[Rs1D];
    if (Rs2D != 5'd0) rd2 = (RegWriteW && RdW == Rs2D) ? ResultW : rf_q[Rs2D];
  end

  // Control, immediate and operand bundle for the ID/EX register.
  always_comb begin
    ex_d        = '0;
    ex_d.rd1    = rd1;
    ex_d.rd2    = rd2;
    ex_d.pc     = PCD;
    ex_d.pc4    = PCPlus4D;
    ex_d.rs1    = Rs1D;
    ex_d.rs2    = Rs2D;
    ex_d.rd     = instrD[11:7];
    ex_d.funct3 = instrD[14:12];
    ex_d.alu_ctl = ALU_ADD;
    case (instrD[6:0])
      OP_R: begin
        ex_d.reg_write = 1'b1;
        ex_d.alu_ctl   = alu_from_f3(instrD[14:12], instrD[30]);
      end
      OP_IMM: begin
        // Only SRAI honours funct7[5]; ADDI with bit 30 set stays ADD.
        ex_d.reg_write = 1'b1;
        ex_d.alu_src   = 1'b1;
        ex_d.alu_ctl   = alu_from_f3(instrD[14:12],
                                     instrD[30] && instrD[14:12] == 3'b101);
        ex_d.imm       = {{20{instrD[31]}}, instrD[31:20]};
      end
      OP_LOAD: begin
        ex_d.reg_write  = 1'b1;
        ex_d.alu_src    = 1'b1;
        ex_d.result_src = 2'b01;
        ex_d.imm        = {{20{instrD[31]}}, instrD[31:20]};
      end
      OP_STORE: begin
        ex_d.mem_write = 1'b1;
        ex_d.alu_src   = 1'b1;
        ex_d.imm       = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      end
      OP_BR: begin
        ex_d.branch  = 1'b1;
        ex_d.alu_ctl = ALU_SUB;
        ex_d.imm     = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      end
      OP_JAL: begin
        ex_d.jump       = 1'b1;
        ex_d.reg_write  = 1'b1;
        ex_d.result_src = 2'b10;
        ex_d.imm        = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      end
      OP_JALR: begin
        ex_d.jalr       = 1'b1;
        ex_d.reg_write  = 1'b1;
        ex_d.result_src = 2'b10;
        ex_d.alu_src    = 1'b1;
        ex_d.imm        = {{20{instrD[31]}}, instrD[31:20]};
      end
      OP_LUI: begin
        ex_d.reg_write = 1'b1;
        ex_d.alu_src   = 1'b1;
        ex_d.alu_ctl   = ALU_PASSB;
        ex_d.imm       = {instrD[31:12], 12'b0};
      end
      OP_AUIPC: begin
        ex_d.reg_write = 1'b1;
        ex_d.alu_src   = 1'b1;
        ex_d.alu_src_a = 1'b1;
        ex_d.imm       = {instrD[31:12], 12'b0};
      end
      default: begin
        ex_d.illegal = 1'b1;
      end
    endcase
  end

  // ID/EX pipeline register: reset, then bubble on flush, else load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ex_q <= '0;
    else if (flush_e) ex_q <= '0;
    else              ex_q <= ex_d;
  end

  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign ImmExtE     = ex_q.imm;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc4;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign Funct3E     = ex_q.funct3;
  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign ALUSrcE     = ex_q.alu_src;
  assign ALUSrcAE    = ex_q.alu_src_a;
  assign BranchE     = ex_q.branch;
  assign JumpE       = ex_q.jump;
  assign JalrE       = ex_q.jalr;
  assign IllegalE    = ex_q.illegal;
  assign ResultSrcE  = ex_q.result_src;
  assign ALUControlE = ex_q.alu_ctl;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes the expected ID/EX
// bundle per issued instruction, a monitor pops and compares after each edge.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        rw, mw, src, srca, br, j, jr, ill;
    logic [1:0]  rsrc;
    logic [3:0]  alu;
  } ex_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instrD = 32'h13, PCD = '0, PCPlus4D = 32'd4;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RdW = '0;
  logic [31:0] ResultW = '0;
  logic        flush_e = 1'b0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [2:0]  Funct3E;
  logic        RegWriteE, MemWriteE, ALUSrcE, ALUSrcAE, BranchE, JumpE, JalrE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;

  decode_stage #(.XLEN(32), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .reset(reset), .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .flush_e(flush_e),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .Funct3E(Funct3E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .BranchE(BranchE), .JumpE(JumpE),
    .JalrE(JalrE), .IllegalE(IllegalE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE)
  );

  always #5 clk = ~clk;

  ex_t act;
  assign act = {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, Funct3E,
                RegWriteE, MemWriteE, ALUSrcE, ALUSrcAE, BranchE, JumpE, JalrE,
                IllegalE, ResultSrcE, ALUControlE};

  int unsigned tests = 0, fails = 0;
  ex_t         expq[$];
  logic [31:0] rf [32];

  // Base ALU operation per funct3: ADD SLL SLT SLTU XOR SRL OR AND
  int unsigned base_op [8] = '{0, 5, 8, 9, 4, 6, 3, 2};

  function automatic logic [31:0] rdreg(input logic [4:0] idx, input logic wen,
                                        input logic [4:0] rdw, input logic [31:0] res);
    if (idx == 0) return 32'd0;
    if (wen && rdw == idx) return res;
    return rf[idx];
  endfunction

  function automatic ex_t model(input logic [31:0] ins, pc, pc4, input logic wen,
                                input logic [4:0] rdw, input logic [31:0] res, input logic fl);
    ex_t e;
    logic [6:0] op;
    logic [2:0] f3;
    int unsigned aop;
    e = '0;
    if (fl) return e;
    op = ins[6:0];
    f3 = ins[14:12];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.f3  = f3;
    e.pc  = pc;
    e.pc4 = pc4;
    e.rd1 = rdreg(e.rs1, wen, rdw, res);
    e.rd2 = rdreg(e.rs2, wen, rdw, res);
    aop = base_op[f3];
    if (op == 7'h33) begin
      e.rw = 1;
      if (ins[30] && f3 == 0) aop = 1;
      if (ins[30] && f3 == 5) aop = 7;
      e.alu = 4'(aop);
    end else if (op == 7'h13) begin
      e.rw = 1; e.src = 1;
      if (ins[30] && f3 == 5) aop = 7;
      e.alu = 4'(aop);
      e.imm = 32'($signed(ins[31:20]));
    end else if (op == 7'h03) begin
      e.rw = 1; e.src = 1; e.rsrc = 2'b01;
      e.imm = 32'($signed(ins[31:20]));
    end else if (op == 7'h23) begin
      e.mw = 1; e.src = 1;
      e.imm = 32'($signed({ins[31:25], ins[11:7]}));
    end else if (op == 7'h63) begin
      e.br = 1; e.alu = 4'd1;
      e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    end else if (op == 7'h6F) begin
      e.j = 1; e.rw = 1; e.rsrc = 2'b10;
      e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    end else if (op == 7'h67) begin
      e.jr = 1; e.rw = 1; e.rsrc = 2'b10; e.src = 1;
      e.imm = 32'($signed(ins[31:20]));
    end else if (op == 7'h37) begin
      e.rw = 1; e.src = 1; e.alu = 4'd10;
      e.imm = ins[31:12] << 12;
    end else if (op == 7'h17) begin
      e.rw = 1; e.src = 1; e.srca = 1;
      e.imm = ins[31:12] << 12;
    end else begin
      e.ill = 1;
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] ins, pc, input logic wen,
                       input logic [4:0] rdw, input logic [31:0] res, input logic fl);
    @(negedge clk);
    instrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = wen; RdW = rdw; ResultW = res; flush_e = fl;
    #1;
    tests++;
    if (Rs1D !== ins[19:15] || Rs2D !== ins[24:20]) begin
      fails++;
      $display("FAIL rs_fields: got %0d/%0d want %0d/%0d", Rs1D, Rs2D, ins[19:15], ins[24:20]);
    end
    expq.push_back(model(ins, pc, pc + 32'd4, wen, rdw, res, fl));
    @(posedge clk);
    if (wen && rdw != 0) rf[rdw] = res;
  endtask

  task automatic rand_issue();
    logic [31:0] ins;
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    int unsigned k;
    ins = $urandom;
    k = $urandom_range(0, 9);
    ins[6:0] = (k == 9) ? 7'($urandom) : ops[k];
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) ins[31:25] = 7'($urandom);
    end
    issue(ins, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 2) != 0),
          5'($urandom), $urandom, ($urandom_range(0, 9) == 0));
  endtask

  // Monitor: compare the ID/EX bundle one time unit after each edge.
  initial begin
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL ex_bundle: got %h want %h (instr field rd=%0d)", act, e, e.rd);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b1;
    #2;
    tests++;
    if (act !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h want 0", act);
    end
    @(negedge clk);
    reset = 1'b0;

    issue(32'h00500093, 32'h10, 0, 0, 0, 0);              // addi x1,x0,5
    issue(32'h00318233, 32'h14, 1, 5'd3, 32'hDEADBEEF, 0); // add x4,x3,x3 with write-through
    issue(32'h00000233, 32'h18, 1, 5'd0, 32'h55, 0);       // add x4,x0,x0 with x0 write
    issue(32'hFE208CE3, 32'h1C, 0, 0, 0, 0);               // beq x1,x2,-8
    issue(32'h010000EF, 32'h20, 0, 0, 0, 0);               // jal x1,+16
    issue(32'h010000EF, 32'h20, 0, 0, 0, 1);               // same, flushed
    issue(32'h0000007F, 32'h24, 0, 0, 0, 0);               // illegal opcode
    issue(32'h40545093, 32'h28, 0, 0, 0, 0);               // srai x1,x8,5
    issue(32'h40000093, 32'h2C, 0, 0, 0, 0);               // addi with bit 30 set stays ADD
    issue(32'h00318233, 32'h30, 0, 0, 0, 0);               // x3 now holds DEADBEEF

    for (int i = 0; i < 300; i++) rand_issue();

    // Asynchronous reset mid-stream: outputs clear without waiting for an edge.
    @(negedge clk);
    instrD = 32'h00500093; RegWriteW = 1'b0; flush_e = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    tests++;
    if (act !== '0) begin
      fails++;
      $display("FAIL reset_midstream: got %h want 0", act);
    end
    for (int i = 0; i < 32; i++) rf[i] = '0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) issue({7'd0, 5'(i + 1), 5'(i), 3'd0, 5'd5, 7'h33}, 32'h40, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) rand_issue();

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the fetch → decode interface (instrD, PCD, PCPlus4D) of the 5-stage RV32I pipeline.
- Decodes the instruction, reads and writes the 32x32 register file, and generates the immediate and the control bundle.
- Registers everything into the ID/EX pipeline register feeding execute.
- Execute uses BranchE/JumpE/JalrE to produce the PCSrc, PCTarget and ALUOut redirect signals that go back to fetch.

Parameters:
- XLEN, 32, datapath width
- NOP_INSTR, 32'h00000013, encoding treated as a no-op; decodes as addi x0,x0,0

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  reset, asynchronous, active-high
- instrD  in  32  instruction from IF/ID
- PCD  in  32  PC of instrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- flush_e  in  1  from hazard unit; load a bubble into ID/EX this edge
- Rs1D  out  5  instrD[19:15], combinational, for hazard unit
- Rs2D  out  5  instrD[24:20], combinational
- RD1E, RD2E  out  32 each  registered source operands
- ImmExtE  out  32  registered sign-extended immediate
- PCE, PCPlus4E  out  32 each  registered PC values
- Rs1E, Rs2E, RdE  out  5 each  registered register indices
- Funct3E  out  3  registered funct3 (branch compare, load/store size)
- RegWriteE, MemWriteE, ALUSrcE, ALUSrcAE, BranchE, JumpE, JalrE, IllegalE  out  1 each  registered controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB

Behaviour:
- Reset (asynchronous): all 31 writable registers = 0; every E output = 0.
- Register file writes: on a rising edge when RegWriteW=1 and RdW≠0. Writes to x0 are ignored; x0 always reads 0.
- Register file reads: combinational, write-through. If RegWriteW=1, RdW≠0 and RdW equals the read index, the read returns ResultW in the same cycle.
- Latency: every E output reflects the instrD present one edge earlier.

Decode by opcode:
- 0110011 R-type: RegWrite=1. ALUControl from funct3 plus funct7[5]: funct7[5]=1 selects SUB/SRA.
- 0010011 I-ALU: RegWrite=1, ALUSrc=1.
  - funct7[5] is honoured only for SRAI (funct3=101).
  - ADDI never decodes as SUB.
- 0000011 load: RegWrite=1, ALUSrc=1, ResultSrc=01, ALUControl ADD.
- 0100011 store: MemWrite=1, ALUSrc=1, ALUControl ADD, S-immediate.
- 1100011 branch: Branch=1, ALUControl SUB, B-immediate.
- 1101111 jal: Jump=1, RegWrite=1, ResultSrc=10, J-immediate.
- 1100111 jalr: Jalr=1, RegWrite=1, ResultSrc=10, ALUSrc=1, ALUControl ADD, I-immediate.
- 0110111 lui: RegWrite=1, ALUSrc=1, ALUControl PASSB, U-immediate.
- 0010111 auipc: RegWrite=1, ALUSrc=1, ALUSrcA=1 (PC), ALUControl ADD, U-immediate.
- Any other opcode: all controls 0, IllegalE=1.

Immediates (all sign-extended from instr[31]):
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- U = {instr[31:12], 12'b0}

Pipeline register updates:
- flush_e=1: at the edge, every E output = 0 (bubble; RegWriteE=MemWriteE=BranchE=JumpE=JalrE=IllegalE=0).
  - Register file write still occurs that edge.
- Priority: reset > flush_e > normal load.
- A write to the same register in the same cycle as a read is covered by the write-through rule.

Test Plan:
- Reset mid-stream with instrD=0x00500093 -> all E outputs 0 immediately; register file reads 0 after reset release.
- instrD=0x00500093 (addi x1,x0,5), PCD=0x10 -> next edge:
  - RdE=1, ImmExtE=5, RegWriteE=1, ALUSrcE=1, ALUControlE=0, RD1E=0, PCE=0x10, PCPlus4E=0x14.
- Write-through: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, instrD=0x00318233 (add x4,x3,x3) -> next edge:
  - RD1E=RD2E=0xDEADBEEF, RdE=4, ALUControlE=0.
  - Then RegWriteW=1, RdW=0, ResultW=0x55 followed by add x4,x0,x0 (0x00000233) -> RD1E=RD2E=0.
- instrD=0xFE208CE3 (beq x1,x2,-8) -> BranchE=1, ImmExtE=0xFFFFFFF8, ALUControlE=1, Funct3E=0, RegWriteE=0.
- instrD=0x010000EF (jal x1,+16) -> JumpE=1, RdE=1, ImmExtE=0x10, ResultSrcE=10.
  - Same instr with flush_e=1 -> all E outputs 0.
- instrD=0x0000007F -> IllegalE=1, all other controls 0.
- instrD=0x40545093 (srai x1,x8,5) -> ALUControlE=7, ImmExtE=0x405.
